// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Divide hardware is built only when MDU_DIV_EN is defined.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH:0] acc, mul_nxt, nxt;
  logic [WIDTH-1:0] opd, ma, mb;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod, res;
  logic ps, sa, sb;
  assign sa = is_signed & in_a[WIDTH-1];
  assign sb = is_signed & in_b[WIDTH-1];
  assign ma = sa ? -in_a : in_a;
  assign mb = sb ? -in_b : in_b;
  // acc holds {carry, partial sum, remaining multiplier bits}
  assign sum = acc[2*WIDTH:WIDTH] + {1'b0, {WIDTH{acc[0]}} & opd};
  assign mul_nxt = {1'b0, sum, acc[WIDTH-1:1]};
  assign prod = ps ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
`ifdef MDU_DIV_EN
  logic op, rs;
  logic [WIDTH:0] sh, diff;
  logic [2*WIDTH:0] div_nxt;
  logic [WIDTH-1:0] rem, quo;
  // acc holds {0, partial remainder, dividend bits shifting into quotient}
  assign sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = sh - {1'b0, opd};
  assign div_nxt = {1'b0, diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]};
  assign rem = rs ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign quo = ps ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign nxt = op ? div_nxt : mul_nxt;
  assign res = div_by_zero ? acc[2*WIDTH-1:0] : op ? {rem, quo} : prod;
`else
  assign nxt = mul_nxt;
  assign res = prod;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          acc <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= res;
          done <= 1'b1;
          state <= DONE;
        end
        default: if (start) begin
          busy <= 1'b1;
          div_by_zero <= 1'b0;
          cnt <= '0;
          ps <= sa ^ sb;
          state <= CALC;
          acc <= {{(WIDTH+1){1'b0}}, op_div ? ma : mb};
          opd <= op_div ? mb : ma;
`ifdef MDU_DIV_EN
          op <= op_div;
          rs <= sa;
          if (op_div && in_b == '0) begin
            div_by_zero <= 1'b1;
            acc <= {1'b0, in_a, {WIDTH{1'b1}}};
            state <= FIX;
          end
`else
          if (op_div) begin
            done <= 1'b1;
            state <= DONE;
          end
`endif
        end else begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst, start, op_div, is_signed;
  logic [31:0] in_a, in_b;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  logic [31:0] m_hi, m_lo, e_hi, e_lo;
  logic e_dz;
  int e_lat;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .is_signed(is_signed),
    .in_a(in_a), .in_b(in_b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic predict(input bit op, input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p, q, r;
    x = sg ? longint'($signed(a)) : longint'(a);
    y = sg ? longint'($signed(b)) : longint'(b);
    e_hi = m_hi;
    e_lo = m_lo;
    e_dz = 1'b0;
    e_lat = 34;
    if (!op) begin
      p = x * y;
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else begin
`ifdef MDU_DIV_EN
      if (b == 0) begin
        e_dz = 1'b1;
        e_hi = a;
        e_lo = 32'hFFFF_FFFF;
        e_lat = 2;
      end else begin
        q = x / y;
        r = x % y;
        e_hi = r[31:0];
        e_lo = q[31:0];
      end
`else
      e_lat = 1;
`endif
    end
  endtask

  task automatic issue(input bit op, input bit sg, input logic [31:0] a, input logic [31:0] b);
    predict(op, sg, a, b);
    op_div = op;
    is_signed = sg;
    in_a = a;
    in_b = b;
    start = 1'b1;
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == 5 && !done) begin
        chk({tag, "_hold_hi"}, hi, m_hi);
        chk({tag, "_hold_lo"}, lo, m_lo);
        chk({tag, "_busy"}, busy, 1);
      end
      if (poke && lat == 5) begin
        start = 1'b1;
        in_a = $urandom;
        in_b = $urandom;
        op_div = ~op_div;
        is_signed = ~is_signed;
      end
      if (poke && lat == 6) start = 1'b0;
    end while (!done && lat < 60);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
    chk({tag, "_dz"}, div_by_zero, e_dz);
    chk({tag, "_busy_done"}, busy, 1);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  task automatic run(input string tag, input bit op, input bit sg, input logic [31:0] a,
                     input logic [31:0] b, input bit poke);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 0);
    issue(op, sg, a, b);
    wait_done(tag, poke);
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    case ($urandom_range(0, 4))
      0: return $urandom_range(0, 40);
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return allow_zero ? 32'h0 : 32'h7;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    op_div = 1'b0;
    is_signed = 1'b0;
    in_a = '0;
    in_b = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;
    run("multu", 0, 0, 32'hFFFF_FFFF, 32'h2, 0);
    chk("multu_hi_k", hi, 32'h1);
    chk("multu_lo_k", lo, 32'hFFFF_FFFE);
    run("mult", 0, 1, 32'hFFFF_FFFD, 32'h7, 0);
    chk("mult_hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_lo_k", lo, 32'hFFFF_FFEB);
    run("div", 1, 1, 32'hFFFF_FFEF, 32'h5, 0);
    run("div_min", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run("divu_z", 1, 0, 32'h1234, 32'h0, 0);
    run("clr_dz", 0, 0, 32'h3, 32'h4, 0);
    run("poke", 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    run("b2b_a", 0, 1, 32'h8000_0000, 32'h8000_0000, 0);
    issue(0, 0, 32'hDEAD_BEEF, 32'h0000_0100);
    wait_done("b2b_b", 0);
    issue(1, 0, 32'h0000_0064, 32'h0000_0007);
    wait_done("b2b_c", 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        issue($urandom_range(0, 1), $urandom_range(0, 1), pick(0), pick(1));
        wait_done("rnd_b2b", 0);
      end else begin
        run("rnd", $urandom_range(0, 1), $urandom_range(0, 1), pick(0), pick(1), $urandom_range(0, 1));
      end
    end
    @(negedge clk);
    issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done;
    end
    chk("midrst_nodone", seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU for the multi-cycle MIPS datapath.
- Sits directly downstream of the main controller. The controller pulses start with is_signed and the operation, holds in its wait state while busy is high, then reads hi/lo for MFHI/MFLO.
- Operands come from the register-file A/B latches.

Parameters:
- WIDTH, 32, operand and HI/LO width. Must be even and ≥ 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request. Ignored while busy and not done.
- op_div  input  1  operation select: 0 = multiply, 1 = divide. Sampled with start.
- is_signed  input  1  signed (MULT/DIV) when 1, unsigned (MULTU/DIVU) when 0. Sampled with start.
- in_a  input  WIDTH  multiplicand or dividend. Sampled with start.
- in_b  input  WIDTH  multiplier or divisor. Sampled with start.
- busy  output  1  high while an operation is in flight, including the done cycle.
- done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle.
- div_by_zero  output  1  sticky flag. Set by a divide with in_b = 0. Cleared by the next accepted start.
- hi  output  WIDTH  HI register: upper product half or remainder.
- lo  output  WIDTH  LO register: lower product half or quotient.

Behaviour:
Reset (rst = 1 at an edge):
- Next state is IDLE.
- busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0.
- Reset overrides an in-flight operation. The partial result is discarded.

States: IDLE, CALC, FIX, DONE.
- IDLE, start = 1:
  - Latch op_div and is_signed.
  - Latch operand magnitudes. If is_signed = 1, a negative operand is two's-complement negated. Unsigned operands are taken raw.
  - Record sign flags: product sign = sa ^ sb; quotient sign = sa ^ sb; remainder sign = sa.
  - Clear counter to 0. Go to CALC.
- IDLE, start = 0: stay in IDLE.
- Divide with in_b = 0 at start:
  - Skip CALC and go to FIX.
  - Result: lo = all ones, hi = in_a (raw, no sign fix).
  - Set div_by_zero.
- CALC: one iteration per cycle. After iteration WIDTH-1 (counter = WIDTH-1), go to FIX.
  - Multiply: shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
- FIX: apply sign corrections to a temp.
  - Negate the 2·WIDTH product if its sign is set.
  - Negate the quotient and the remainder independently per their signs.
  - Go to DONE.
- DONE:
  - hi/lo are written on the edge entering DONE, so the new values are visible while done = 1.
  - done = 1 for exactly this cycle.
  - start = 1 in DONE is accepted (back-to-back) and goes to CALC. Otherwise go to IDLE.

Latency:
- Start sampled at edge E0; done is high in the cycle following edge E(WIDTH+1).
- That is WIDTH+2 cycles after the start cycle: 34 for WIDTH = 32.
- Divide-by-zero case: done high 2 cycles after the start cycle.

Busy rule:
- busy = 1 in CALC, FIX and DONE.
- The controller may issue start in the DONE cycle. In CALC or FIX, start is ignored with no side effects.

hi/lo hold:
- hi/lo hold their value from reset or the previous op until the DONE edge. Reading them mid-operation returns the old result.

Arithmetic edge cases:
- Signed -2^(W-1) / -1 yields quotient 0x80000000, remainder 0. This falls out of the magnitude arithmetic; no trap.
- All arithmetic is modulo 2^WIDTH per half.

Optional Feature:
- Macro: MDU_DIV_EN.
- Defined: full behaviour as above.
- Undefined:
  - Divide hardware is omitted.
  - start with op_div = 1 goes IDLE → DONE. done is pulsed 1 cycle after start.
  - hi/lo are unchanged and div_by_zero = 0.
  - Multiply is unaffected.

Test Plan:
- Reset mid-operation: start MULTU, assert rst at cycle 10 → next cycle busy = 0, done = 0, hi = 0, lo = 0; no done pulse follows.
- Unsigned multiply: MULTU in_a = 0xFFFFFFFF, in_b = 0x00000002 → done at cycle 34; hi = 0x00000001, lo = 0xFFFFFFFE.
- Signed multiply: MULT in_a = 0xFFFFFFFD (-3), in_b = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (-21).
- Signed divide: DIV in_a = -17 (0xFFFFFFEF), in_b = 5 → lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFE (-2). Check -2^31 / -1 → lo = 0x80000000, hi = 0.
- Divide by zero: DIVU in_a = 0x1234, in_b = 0 → done 2 cycles after start; lo = 0xFFFFFFFF, hi = 0x1234, div_by_zero = 1. Next start clears div_by_zero.
- Handshake:
  - start during CALC (cycle 5) → ignored; result still matches the original operands.
  - start in the DONE cycle → accepted; second done exactly 34 cycles later.
  - With MDU_DIV_EN undefined, DIV → done after 1 cycle, hi/lo unchanged.
